rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter
//
// Eight-requester round-robin arbiter with a per-tenure hold limit.
// A grant is issued from IDLE one cycle after a request is sampled. The
// search starts at a rotating pointer, so every requester gets a turn. An
// owner keeps the grant until it drops its request. With HOLD_MAX != 0 the
// owner is also forced off after HOLD_MAX cycles, which raises a one-cycle
// timeout pulse. Every release is followed by at least one idle cycle
// (break-before-make).
//
// Parameters
//   HOLD_MAX    : maximum grant cycles per tenure (0 = unlimited), 0..255
//
// Ports
//   clk         : in  - clock, rising edge
//   rst_n       : in  - asynchronous active-low reset
//   en          : in  - enables new grants (does not abort a tenure)
//   req[7:0]    : in  - request vector, bit i from requester i
//   grant[7:0]  : out - one-hot grant to the current owner, 0 when idle
//   grant_idx   : out - index of the current / most recent owner
//   grant_valid : out - high while a grant is active
//   timeout     : out - one-cycle pulse following a forced release
//   state_o     : out - FSM state for observation (0 = IDLE, 1 = GRANT)
//
// Handshake: req[i] is a level request, not a pulse. The arbiter never
// latches or queues it. A requester owns the bus in every cycle where its
// grant bit is high, and it releases the bus by dropping req[i]. A request
// from a non-owner is only considered in an IDLE cycle.
// ---------------------------------------------------------------------------
module rr_grant_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic       state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [7:0] hold_cnt_q;

    // First set request bit at or above ptr_q, wrapping 7 -> 0. The loop
    // runs from the far end toward ptr_q, so the closest hit is written
    // last and wins.
    logic       pick_found;
    logic [2:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr_q + 3'(k)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 3'(k);
            end
        end
    end

    logic owner_req;
    logic hold_hit;

    assign owner_req = req[grant_idx];
    assign hold_hit  = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            grant       <= 8'd0;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && pick_found) begin
                        state_q     <= GRANT;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        grant       <= 8'd1 << pick_idx;
                        ptr_q       <= pick_idx + 3'd1;
                        hold_cnt_q  <= 8'd1;
                    end
                end
                GRANT: begin
                    // A dropped request takes precedence over the hold
                    // limit, so a simultaneous drop counts as a normal
                    // release.
                    if (!owner_req || hold_hit) begin
                        state_q     <= IDLE;
                        grant_valid <= 1'b0;
                        grant       <= 8'd0;
                        hold_cnt_q  <= 8'd0;
                        timeout     <= owner_req;
                    end else if (hold_cnt_q != 8'hFF) begin
                        // Saturate so that an unlimited tenure never wraps.
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state_o = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for rr_grant_arbiter. Three instances (HOLD_MAX = 15, 4 and 0)
// share the same stimulus. Each instance is compared every cycle against a
// tenure-level reference model. Directed scenarios add explicit checks of
// the expected waveforms.
// ---------------------------------------------------------------------------
module tb_rr_grant_arbiter;

    localparam int N = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic [7:0] g   [N];
    logic [2:0] gi  [N];
    logic       gv  [N];
    logic       to  [N];
    logic       st  [N];

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance: owner (-1 = none), cycles granted
    // in the current tenure, next search start, last owner, timeout.
    int hm      [N] = '{15, 4, 0};
    int m_owner [N];
    int m_len   [N];
    int m_ptr   [N];
    int m_last  [N];
    int m_to    [N];

    rr_grant_arbiter #(.HOLD_MAX(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g[0]), .grant_idx(gi[0]), .grant_valid(gv[0]),
        .timeout(to[0]), .state_o(st[0])
    );

    rr_grant_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g[1]), .grant_idx(gi[1]), .grant_valid(gv[1]),
        .timeout(to[1]), .state_o(st[1])
    );

    rr_grant_arbiter #(.HOLD_MAX(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g[2]), .grant_idx(gi[2]), .grant_valid(gv[2]),
        .timeout(to[2]), .state_o(st[2])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: obs=time_expired exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_owner[i] = -1;
            m_len[i]   = 0;
            m_ptr[i]   = 0;
            m_last[i]  = 0;
            m_to[i]    = 0;
        end
    endtask

    // Advance every model by one rising edge, using the inputs at that edge.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_owner[i] >= 0) begin
                if (!req[m_owner[i]]) begin
                    m_owner[i] = -1;
                    m_to[i]    = 0;
                end else if (hm[i] != 0 && m_len[i] == hm[i]) begin
                    m_owner[i] = -1;
                    m_to[i]    = 1;
                end else begin
                    m_len[i]++;
                    m_to[i] = 0;
                end
            end else begin
                m_to[i] = 0;
                if (en && req != 8'd0) begin
                    for (int k = 0; k < 8; k++) begin
                        int p;
                        p = (m_ptr[i] + k) % 8;
                        if (m_owner[i] < 0 && req[p]) begin
                            m_owner[i] = p;
                            m_last[i]  = p;
                            m_len[i]   = 1;
                            m_ptr[i]   = (p + 1) % 8;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic [7:0] eg;
            eg = (m_owner[i] >= 0) ? 8'(1 << m_owner[i]) : 8'd0;
            check($sformatf("model_grant[%0d]", i), 32'(g[i]), 32'(eg));
            check($sformatf("model_idx[%0d]", i), 32'(gi[i]), 32'(m_last[i]));
            check($sformatf("model_valid[%0d]", i), 32'(gv[i]), 32'(m_owner[i] >= 0));
            check($sformatf("model_timeout[%0d]", i), 32'(to[i]), 32'(m_to[i]));
            check($sformatf("model_state[%0d]", i), 32'(st[i]), 32'(m_owner[i] >= 0));
            check($sformatf("onehot0[%0d]", i), 32'($onehot0(g[i])), 32'd1);
            check($sformatf("valid_eq_or[%0d]", i), 32'(gv[i]), 32'(|g[i]));
        end
    endtask

    // ---------------- drivers ----------------
    // One rising edge, then compare all instances 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges. Outputs must clear
    // before any further edge.
    task automatic do_reset();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("async_rst_grant[%0d]", i), 32'(g[i]), 32'd0);
            check($sformatf("async_rst_valid[%0d]", i), 32'(gv[i]), 32'd0);
        end
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] eg;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'd0;
        model_reset();
        #1;
        check_all();
        check("reset_grant", 32'(g[0]), 32'd0);
        check("reset_idx", 32'(gi[0]), 32'd0);
        check("reset_timeout", 32'(to[0]), 32'd0);
        cycle();
        cycle();
        #2;
        rst_n = 1'b1;

        // Wrap priority: 0 first, then 7 after a one-cycle gap.
        req = 8'h81; en = 1'b1;
        cycle();
        check("wrap_first", 32'(g[0]), 32'h01);
        req = 8'h80;
        cycle();
        check("wrap_gap", 32'(g[0]), 32'h00);
        cycle();
        check("wrap_second", 32'(g[0]), 32'h80);
        req = 8'h00;
        cycle();

        // All requesting with HOLD_MAX=15: full rotation with timeout gaps.
        do_reset();
        req = 8'hFF; en = 1'b1;
        for (int r = 0; r < 9; r++) begin
            eg = 8'(1 << (r % 8));
            for (int c = 0; c < 15; c++) begin
                cycle();
                check($sformatf("rot_grant_r%0d_c%0d", r, c), 32'(g[0]), 32'(eg));
                check($sformatf("rot_to0_r%0d_c%0d", r, c), 32'(to[0]), 32'd0);
            end
            cycle();
            check($sformatf("rot_gap_r%0d", r), 32'(g[0]), 32'd0);
            check($sformatf("rot_to1_r%0d", r), 32'(to[0]), 32'd1);
        end
        req = 8'h00;
        cycle();

        // Lone requester with HOLD_MAX=4: forced off and then re-granted.
        do_reset();
        req = 8'h08; en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check($sformatf("lone_grant_c%0d", c), 32'(g[1]), 32'h08);
        end
        cycle();
        check("lone_gap", 32'(g[1]), 32'h00);
        check("lone_timeout", 32'(to[1]), 32'd1);
        cycle();
        check("lone_regrant", 32'(g[1]), 32'h08);
        check("lone_regrant_to", 32'(to[1]), 32'd0);
        // Owner drops on the edge where the limit is reached: no timeout.
        for (int c = 0; c < 3; c++) begin
            cycle();
            check($sformatf("edge_grant_c%0d", c), 32'(g[1]), 32'h08);
        end
        req = 8'h00;
        cycle();
        check("edge_drop_grant", 32'(g[1]), 32'h00);
        check("edge_drop_to", 32'(to[1]), 32'd0);
        cycle();

        // en dropped mid-tenure: the tenure runs on, then no new grants.
        do_reset();
        req = 8'h04; en = 1'b1;
        cycle();
        check("en_first", 32'(g[0]), 32'h04);
        en = 1'b0; req = 8'h14;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check($sformatf("en_hold_c%0d", c), 32'(g[0]), 32'h04);
        end
        req = 8'h10;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check($sformatf("en_off_c%0d", c), 32'(g[0]), 32'h00);
        end
        en = 1'b1;
        cycle();
        check("en_back", 32'(g[0]), 32'h10);
        req = 8'h00;
        cycle();

        // Reset mid-tenure, then priority restarts at requester 0.
        req = 8'h01;
        cycle();
        cycle();
        check("mid_rst_pre", 32'(g[0]), 32'h01);
        do_reset();
        req = 8'h06;
        cycle();
        check("post_rst_grant", 32'(g[0]), 32'h02);
        req = 8'h00;
        cycle();

        // HOLD_MAX=0: the tenure lasts as long as the request.
        do_reset();
        req = 8'h20;
        for (int c = 0; c < 40; c++) begin
            cycle();
            check($sformatf("nolimit_grant_c%0d", c), 32'(g[2]), 32'h20);
            check($sformatf("nolimit_to_c%0d", c), 32'(to[2]), 32'd0);
        end
        req = 8'h00;
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 3) == 0) begin
                req = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 7) == 0) begin
                req = req & ~(8'd1 << $urandom_range(0, 7));
            end
            en = ($urandom_range(0, 9) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
